booth_mul_seq: RTL and testbench

Parametrised sequential radix-4 Booth multiplier with a valid/ready handshake. It is the next-generation multiplier for the adders/multipliers chip, generalised in operand width, and it selects signed or unsigned operation per transaction. It carries a sideband tag through with each operation. It computes the full double-width product over WIDTH/2+1 cycles, so one small datapath serves the arithmetic units that do not need single-cycle throughput.

---
 rtl/mul_pkg.sv | 31 +++
 rtl/booth_enc.sv | 31 +++
 rtl/booth_mul_seq.sv | 97 +++++++++
 tb/tb_booth_mul_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, radix-4 digit
// controls, and the iteration-count helper.
package mul_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Radix-4 digit as magnitude select (one/two) plus negate.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_dig_t;

  function automatic int calc_iter(input int width);
    return width / 2 + 1;
  endfunction

  function automatic booth_dig_t booth_decode(input logic [2:0] win);
    booth_dig_t d;
    d = '0;
    case (win)
      3'b001, 3'b010: d.one = 1'b1;
      3'b011:         d.two = 1'b1;
      3'b100:         begin d.neg = 1'b1; d.two = 1'b1; end
      3'b101, 3'b110: begin d.neg = 1'b1; d.one = 1'b1; end
      default:        d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_enc.sv
// Combinational radix-4 Booth partial product: window digit times the extended
// multiplicand, sign-extended to accumulator width, not yet shifted.
module booth_enc
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         win,
  input  logic [WIDTH+1:0]   a,
  output logic [2*WIDTH+3:0] pp
);

  localparam int AW = 2 * WIDTH + 4;

  booth_dig_t     dig;
  logic [AW-1:0]  a_ext;
  logic [AW-1:0]  mag;

  always_comb begin
    dig   = booth_decode(win);
    a_ext = {{(AW - WIDTH - 2){a[WIDTH+1]}}, a};
    mag   = '0;
    if (dig.one) begin
      mag = a_ext;
    end else if (dig.two) begin
      mag = a_ext << 1;
    end
    pp = dig.neg ? -mag : mag;
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per transaction, with a
// tag carried alongside. One digit per cycle, WIDTH/2+1 cycles per product.
module booth_mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               out_zero,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int ITER = calc_iter(WIDTH);
  localparam int EW   = WIDTH + 2;
  localparam int AW   = 2 * WIDTH + 4;
  localparam int CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [EW-1:0]   a_q;
  logic [EW:0]     b_q;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   pp;
  logic [AW-1:0]   pp_sh;
  logic [TAG_W-1:0] tag_q;
  logic [EW-1:0]   a_ext;
  logic [EW-1:0]   b_ext;
  logic            accept;

  assign a_ext  = {{2{in_signed & in_a[WIDTH-1]}}, in_a};
  assign b_ext  = {{2{in_signed & in_b[WIDTH-1]}}, in_b};
  assign accept = in_valid && in_ready;

  // b_q holds the multiplier with b[-1] appended; shifting right by two each
  // cycle keeps the current Booth window in the low three bits.
  booth_enc #(.WIDTH(WIDTH)) u_enc (
    .win (b_q[2:0]),
    .a   (a_q),
    .pp  (pp)
  );

  assign pp_sh = pp << {count, 1'b0};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (count == LAST) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      tag_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q   <= a_ext;
        b_q   <= {b_ext, 1'b0};
        acc   <= '0;
        count <= '0;
        tag_q <= in_tag;
      end else if (state == CALC) begin
        acc   <= acc + pp_sh;
        b_q   <= b_q >> 2;
        count <= (count == LAST) ? '0 : count + CW'(1);
      end
    end
  end

  // Result outputs are gated by out_valid so they read zero outside DONE.
  assign in_ready  = (state == IDLE) && rst;
  assign out_valid = (state == DONE);
  assign out_prod  = out_valid ? acc[2*WIDTH-1:0] : '0;
  assign out_zero  = out_valid && (acc[2*WIDTH-1:0] == '0);
  assign out_tag   = out_valid ? tag_q : '0;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq: a 32-bit and an 8-bit instance sharing one
// clock and reset.
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        in_valid = 1'b0, in_ready, in_signed = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [0:0]  in_tag = '0, out_tag;
  logic [63:0] out_prod;
  logic        out_zero;

  logic        w8_in_valid = 1'b0, w8_in_ready, w8_in_signed = 1'b0, w8_out_valid, w8_out_ready = 1'b0;
  logic [7:0]  w8_in_a = '0, w8_in_b = '0;
  logic [0:0]  w8_in_tag = '0, w8_out_tag;
  logic [15:0] w8_out_prod;
  logic        w8_out_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_mul_seq #(.WIDTH(32), .TAG_W(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
    .out_zero(out_zero), .out_tag(out_tag)
  );

  booth_mul_seq #(.WIDTH(8), .TAG_W(1)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(w8_in_valid), .in_ready(w8_in_ready), .in_a(w8_in_a), .in_b(w8_in_b),
    .in_signed(w8_in_signed), .in_tag(w8_in_tag),
    .out_valid(w8_out_valid), .out_ready(w8_out_ready), .out_prod(w8_out_prod),
    .out_zero(w8_out_zero), .out_tag(w8_out_tag)
  );

  // Accept one operation, scramble the inputs afterwards, and wait for
  // out_valid; lat is the number of edges after the accepting edge.
  task automatic run32(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic t, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_signed = s; in_tag = t; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_signed = ~s; in_tag = ~t;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume32();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic s, output int lat);
    @(negedge clk);
    w8_in_a = a; w8_in_b = b; w8_in_signed = s; w8_in_tag = 1'b1; w8_in_valid = 1'b1;
    @(posedge clk);
    #1;
    w8_in_valid = 1'b0; w8_in_a = ~a; w8_in_b = ~b;
    lat = 0;
    while (!w8_out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume8();
    @(negedge clk);
    w8_out_ready = 1'b1;
    @(posedge clk);
    #1;
    w8_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++;
    if ({out_valid, out_prod, out_zero, out_tag} !== 67'd0) begin
      errors++; $display("FAIL reset_outputs got v=%b p=%h z=%b t=%b want all 0", out_valid, out_prod, out_zero, out_tag);
    end
    checks++;
    if ({w8_in_ready, w8_out_valid, w8_out_prod} !== 18'd0) begin
      errors++; $display("FAIL reset_w8 got r=%b v=%b p=%h want 0", w8_in_ready, w8_out_valid, w8_out_prod);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_signed_basic();
    int lat;
    run32(32'd5, 32'hFFFF_FFFD, 1'b1, 1'b1, lat);
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL latency32 got %0d want 17", lat); end
    checks++;
    if (out_prod !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL prod_5x-3 got %h want fffffffffffffff1", out_prod); end
    checks++;
    if (out_zero !== 1'b0 || out_tag !== 1'b1) begin
      errors++; $display("FAIL flags_5x-3 got z=%b t=%b want z=0 t=1", out_zero, out_tag);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_in_done got %b want 0", in_ready); end
    consume32();
  endtask

  task automatic test_extremes();
    int lat;
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
    checks++;
    if (out_prod !== 64'hFFFF_FFFE_0000_0001 || out_tag !== 1'b0) begin
      errors++; $display("FAIL umax_sq got %h t=%b want fffffffe00000001 t=0", out_prod, out_tag);
    end
    consume32();
    run32(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, lat);
    checks++;
    if (out_prod !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL smin_sq got %h want 4000000000000000", out_prod); end
    consume32();
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, lat);
    checks++;
    if (out_prod !== 64'd1) begin errors++; $display("FAIL sneg1_sq got %h want 1", out_prod); end
    consume32();
    run32(32'h8000_0000, 32'd2, 1'b0, 1'b0, lat);
    checks++;
    if (out_prod !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL u_msb_x2 got %h want 100000000", out_prod); end
    consume32();
  endtask

  task automatic test_zero_and_small();
    int lat;
    run32(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1, lat);
    checks++;
    if (out_prod !== 64'd0 || out_zero !== 1'b1) begin
      errors++; $display("FAIL zero_prod got %h z=%b want 0 z=1", out_prod, out_zero);
    end
    consume32();
    run32(32'h0003_5AAB, 32'd1, 1'b0, 1'b0, lat);
    checks++;
    if (out_prod !== 64'h35AAB || out_zero !== 1'b0) begin
      errors++; $display("FAIL small_x1 got %h z=%b want 35aab z=0", out_prod, out_zero);
    end
    consume32();
  endtask

  task automatic test_backpressure();
    int lat;
    run32(32'd7, 32'd9, 1'b0, 1'b1, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0]; in_a = 32'd3; in_b = 32'd3; in_signed = 1'b0; in_tag = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_prod !== 64'd63 || out_tag !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_%0d got v=%b p=%h t=%b r=%b want v=1 p=3f t=1 r=0", i, out_valid, out_prod, out_tag, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midcalc();
    int lat;
    logic seen;
    @(negedge clk);
    in_a = 32'd1234; in_b = 32'd5678; in_signed = 1'b0; in_tag = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_prod, out_zero, out_tag} !== 68'd0) begin
      errors++; $display("FAIL async_reset got r=%b v=%b p=%h z=%b t=%b want all 0", in_ready, out_valid, out_prod, out_zero, out_tag);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL discarded_result got out_valid=1 want 0"); end
    run32(32'd8, 32'd2, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 17 || out_prod !== 64'd16) begin
      errors++; $display("FAIL after_reset got lat=%0d p=%h want lat=17 p=10", lat, out_prod);
    end
    consume32();
  endtask

  task automatic test_width8();
    int lat;
    run8(8'h80, 8'h80, 1'b1, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL latency8 got %0d want 5", lat); end
    checks++;
    if (w8_out_prod !== 16'h4000 || w8_out_tag !== 1'b1) begin
      errors++; $display("FAIL w8_smin_sq got %h t=%b want 4000 t=1", w8_out_prod, w8_out_tag);
    end
    consume8();
    run8(8'hFF, 8'hFF, 1'b0, lat);
    checks++;
    if (w8_out_prod !== 16'hFE01 || lat !== 5) begin
      errors++; $display("FAIL w8_umax_sq got %h lat=%0d want fe01 lat=5", w8_out_prod, lat);
    end
    consume8();
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_extremes();
    test_zero_and_small();
    test_backpressure();
    test_reset_midcalc();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
